// File: rtl/serial_bus_arbiter_if.sv
// Signal bundle shared by the serial bus masters, the arbiter and the slave-side bus.
// The arbiter connects through the slave modport; master-side agents use the master modport.
interface serial_bus_arbiter_if #(
  parameter int N_MASTERS = 2
);
  localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] M_REQ;
  logic [N_MASTERS-1:0] M_UTIL;
  logic [N_MASTERS-1:0] M_RW;
  logic [N_MASTERS-1:0] M_BUS_OUT;
  logic [N_MASTERS-1:0] M_GRANT;
  logic [N_MASTERS-1:0] M_ACK;
  logic [N_MASTERS-1:0] M_BUS_IN;
  logic                 S_ACK;
  logic                 S_BUS_IN;
  logic                 S_BUS_OUT;
  logic                 S_RW;
  logic                 S_UTIL;
  logic                 BUS_BUSY;
  logic [ID_W-1:0]      GRANT_ID;
  logic                 TIMEOUT_ERR;

  modport slave (
    input  M_REQ, M_UTIL, M_RW, M_BUS_OUT, S_ACK, S_BUS_IN,
    output M_GRANT, M_ACK, M_BUS_IN, S_BUS_OUT, S_RW, S_UTIL,
           BUS_BUSY, GRANT_ID, TIMEOUT_ERR
  );

  modport master (
    output M_REQ, M_UTIL, M_RW, M_BUS_OUT, S_ACK, S_BUS_IN,
    input  M_GRANT, M_ACK, M_BUS_IN, S_BUS_OUT, S_RW, S_UTIL,
           BUS_BUSY, GRANT_ID, TIMEOUT_ERR
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbitration for the shared single-wire serial bus, with an idle watchdog
// that revokes a grant, plus a small checker module holding the structural invariants.
module serial_bus_arbiter_chk #(
  parameter int N_MASTERS = 2,
  parameter int ID_W      = 1
) (
  input logic                 CLK,
  input logic                 RSTN,
  input logic [N_MASTERS-1:0] grant,
  input logic                 busy,
  input logic [ID_W-1:0]      grant_id,
  input logic                 err
);
  a_grant_onehot: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(grant));
  a_busy_match:   assert property (@(posedge CLK) disable iff (!RSTN) busy == (|grant));
  a_id_idle:      assert property (@(posedge CLK) disable iff (!RSTN)
                                   !busy |-> (grant_id == {ID_W{1'b0}}));
  a_err_revokes:  assert property (@(posedge CLK) disable iff (!RSTN)
                                   err |-> (grant == {N_MASTERS{1'b0}}));
endmodule

module serial_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 64
) (
  input logic                 CLK,
  input logic                 RSTN,
  serial_bus_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_MASTERS);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]      WD_ZERO = {WD_W{1'b0}};
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]      WD_SAT  = {WD_W{1'b1}};
  localparam logic [ID_W-1:0]      ID_ZERO = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]      ID_LAST = ID_W'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] G_ZERO  = {N_MASTERS{1'b0}};
  localparam logic [N_MASTERS-1:0] G_BIT0  = {{(N_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      rr_last_q, rr_last_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;

  logic                 any_req_s;
  logic                 owner_req_s;
  logic                 owner_util_s;
  logic [ID_W-1:0]      rr_base_s;
  logic [ID_W-1:0]      pick_s;
  logic                 take_s;
  logic                 drop_s;

  // First requester scanning upward from last+1; the descending loop leaves the nearest one.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                              input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    win = last;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % N_MASTERS);
      if (req[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

  function automatic logic [WD_W-1:0] wdog_inc(input logic [WD_W-1:0] v);
    return (v == WD_SAT) ? v : v + {{(WD_W-1){1'b0}}, 1'b1};
  endfunction

  // Owner view and arbitration inputs; RELEASE re-arbitrates against the departing owner.
  assign any_req_s    = |bus.M_REQ;
  assign owner_req_s  = bus.M_REQ[owner_q];
  assign owner_util_s = bus.M_UTIL[owner_q];
  assign rr_base_s    = (state_q == ST_RELEASE) ? owner_q : rr_last_q;
  assign pick_s       = rr_pick(bus.M_REQ, rr_base_s);

  // Bus muxing straight from the registered one-hot grant; nothing reaches a non-owner.
  assign bus.S_BUS_OUT   = |(grant_q & bus.M_BUS_OUT);
  assign bus.S_RW        = |(grant_q & bus.M_RW);
  assign bus.S_UTIL      = |(grant_q & bus.M_UTIL);
  assign bus.M_ACK       = grant_q & {N_MASTERS{bus.S_ACK}};
  assign bus.M_BUS_IN    = grant_q & {N_MASTERS{bus.S_BUS_IN}};
  assign bus.M_GRANT     = grant_q;
  assign bus.BUS_BUSY    = busy_q;
  assign bus.GRANT_ID    = grant_id_q;
  assign bus.TIMEOUT_ERR = err_q;

  // Next-state logic: per-state decisions set take/drop, applied once below the case.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    grant_id_d = grant_id_q;
    rr_last_d  = rr_last_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    wdog_d     = wdog_q;
    take_s     = 1'b0;
    drop_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          take_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (!owner_req_s) begin
          drop_s = 1'b1;
        end else if (owner_util_s) begin
          state_d = ST_ACTIVE;
          wdog_d  = WD_ZERO;
        end else if (wdog_q == WD_LAST) begin
          drop_s = 1'b1;
          err_d  = 1'b1;
        end else begin
          wdog_d = wdog_inc(wdog_q);
        end
      end
      ST_ACTIVE: begin
        // A held REQ with UTIL low is a HOLD phase: grant stays, only the watchdog runs.
        if (!owner_req_s) begin
          drop_s = 1'b1;
        end else if (owner_util_s) begin
          wdog_d = WD_ZERO;
        end else if (wdog_q == WD_LAST) begin
          drop_s = 1'b1;
          err_d  = 1'b1;
        end else begin
          wdog_d = wdog_inc(wdog_q);
        end
      end
      ST_RELEASE: begin
        rr_last_d = owner_q;
        if (any_req_s) begin
          take_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        drop_s = 1'b1;
      end
    endcase

    case ({take_s, drop_s})
      2'b10: begin
        state_d    = ST_GRANTED;
        grant_d    = G_BIT0 << pick_s;
        owner_d    = pick_s;
        grant_id_d = pick_s;
        busy_d     = 1'b1;
        wdog_d     = WD_ZERO;
      end
      2'b01: begin
        state_d    = ST_RELEASE;
        grant_d    = G_ZERO;
        grant_id_d = ID_ZERO;
        busy_d     = 1'b0;
        wdog_d     = WD_ZERO;
      end
      default: begin
        grant_d = grant_q;
        owner_d = owner_q;
      end
    endcase
  end

  // State and output registers; reset makes master 0 the first winner.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      grant_q    <= G_ZERO;
      owner_q    <= ID_ZERO;
      grant_id_q <= ID_ZERO;
      rr_last_q  <= ID_LAST;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wdog_q     <= WD_ZERO;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      grant_id_q <= grant_id_d;
      rr_last_q  <= rr_last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  serial_bus_arbiter_chk #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) u_chk (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .grant    (grant_q),
    .busy     (busy_q),
    .grant_id (grant_id_q),
    .err      (err_q)
  );
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench: stimulus queues expected output vectors with their cycle stamps, and a
// negedge monitor pops and compares one entry every time the observed output vector changes.
module tb_serial_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  typedef struct {
    int          cyc;
    logic [11:0] v;
    string       tag;
  } exp_t;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b1;
  int          cyc  = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [11:0] prev_obs = 12'hfff;
  logic [11:0] mon_obs;
  exp_t        mon_e;
  exp_t        left_e;
  exp_t        exp_q[$];
  logic [7:0]  pat;
  logic        last_b;

  serial_bus_arbiter_if #(.N_MASTERS(N)) bus ();

  serial_bus_arbiter #(
    .N_MASTERS (N),
    .TIMEOUT   (TO)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [11:0] obs_now();
    return {bus.M_GRANT, bus.M_ACK, bus.M_BUS_IN, bus.S_BUS_OUT, bus.S_RW, bus.S_UTIL,
            bus.BUS_BUSY, bus.GRANT_ID, bus.TIMEOUT_ERR};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Vector order: grant, ack, bus_in, s_bus_out, s_rw, s_util, busy, id, err.
  task automatic expect_obs(input string tag, input int d, input logic [1:0] g,
                            input logic [1:0] ack, input logic [1:0] bin, input logic sbo,
                            input logic srw, input logic sut, input logic busy,
                            input logic id, input logic err);
    exp_t e;
    e.cyc = cyc + d;
    e.v   = {g, ack, bin, sbo, srw, sut, busy, id, err};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic expect_idle(input string tag, input int d);
    expect_obs(tag, d, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      mon_obs = obs_now();
      if (mon_obs !== prev_obs) begin
        prev_obs = mon_obs;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: got %03h at cycle %0d, required no change",
                   mon_obs, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_obs !== mon_e.v || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL %s: got %03h at cycle %0d, required %03h at cycle %0d",
                     mon_e.tag, mon_obs, cyc, mon_e.v, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    bus.M_REQ     = 2'b00;
    bus.M_UTIL    = 2'b00;
    bus.M_RW      = 2'b00;
    bus.M_BUS_OUT = 2'b00;
    bus.S_ACK     = 1'b0;
    bus.S_BUS_IN  = 1'b0;
    #1 RSTN = 1'b0;
    tick(2);
    expect_idle("reset_state", 0);
    mon_en = 1'b1;
    tick(1);
    RSTN = 1'b1;
    tick(2);

    // Single request from master 0: grant one cycle after REQ is sampled.
    bus.M_REQ = 2'b01;
    expect_obs("t1_grant_m0", 1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    bus.M_REQ = 2'b00;
    expect_idle("t1_release", 1);
    tick(3);

    // Master 1 owns the bus and shifts 0xA5; master 0 drives junk that must be ignored.
    bus.M_REQ     = 2'b10;
    bus.M_UTIL    = 2'b01;
    bus.M_RW      = 2'b01;
    bus.M_BUS_OUT = 2'b01;
    expect_obs("t3_grant_m1", 1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(2);
    bus.M_UTIL = 2'b11;
    bus.M_RW   = 2'b11;
    expect_obs("t3_util_rw", 0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    pat    = 8'hA5;
    last_b = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick(1);
      bus.M_BUS_OUT[1] = pat[i];
      if (pat[i] != last_b) begin
        expect_obs("t3_serial_bit", 0, 2'b10, 2'b00, 2'b00, pat[i], 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      last_b = pat[i];
    end
    tick(1);
    bus.S_ACK    = 1'b1;
    bus.S_BUS_IN = 1'b1;
    expect_obs("t3_ack_owner", 0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    bus.S_ACK    = 1'b0;
    bus.S_BUS_IN = 1'b0;
    expect_obs("t3_ack_off", 0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    bus.M_REQ     = 2'b00;
    bus.M_UTIL    = 2'b00;
    bus.M_RW      = 2'b00;
    bus.M_BUS_OUT = 2'b00;
    expect_obs("t3_lines_off", 0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_idle("t3_release", 1);
    tick(3);

    // Both masters request; each drops REQ 20 cycles after its grant, one zero cycle between.
    bus.M_REQ  = 2'b11;
    bus.M_UTIL = 2'b11;
    expect_obs("t2_grant_m0", 1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(21);
    bus.M_REQ = 2'b10;
    expect_idle("t2_gap_a", 1);
    expect_obs("t2_grant_m1", 2, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    bus.M_REQ = 2'b11;
    tick(21);
    bus.M_REQ = 2'b01;
    expect_idle("t2_gap_b", 1);
    expect_obs("t2_grant_m0_again", 2, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    bus.M_REQ = 2'b11;
    tick(5);
    bus.M_REQ  = 2'b00;
    bus.M_UTIL = 2'b00;
    expect_obs("t2_util_off", 0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_idle("t2_release", 1);
    tick(3);

    // Owner holds REQ with UTIL low: revoked with an error pulse 8 cycles after the grant.
    bus.M_REQ = 2'b10;
    expect_obs("t4_grant_m1", 1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_obs("t4_timeout", 9, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_idle("t4_err_clear", 10);
    tick(9);
    bus.M_REQ = 2'b00;
    tick(4);

    // HOLD phase of 5 cycles inside ACTIVE, then long activity: grant must stay put.
    bus.M_REQ  = 2'b01;
    bus.M_UTIL = 2'b01;
    expect_obs("t5_grant_m0", 1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);
    bus.M_UTIL = 2'b00;
    expect_obs("t5_hold", 0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(5);
    bus.M_UTIL = 2'b01;
    expect_obs("t5_resume", 0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(10);

    // Asynchronous reset in the middle of ACTIVE, both masters then competing.
    bus.M_REQ = 2'b11;
    RSTN      = 1'b0;
    expect_idle("t6_async_reset", 0);
    tick(2);
    RSTN       = 1'b1;
    bus.M_UTIL = 2'b00;
    expect_obs("t6_first_grant_m0", 1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    bus.M_REQ = 2'b00;
    expect_idle("t6_release", 1);
    tick(4);

    while (exp_q.size() > 0) begin
      left_e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no change, required %03h at cycle %0d", left_e.tag, left_e.v,
               left_e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
